// File: rtl/mux_serial_tx.sv
// Serial transmitter driving an 8:1 mux: start bit, 8 mux-selected data bits LSB-first, stop bit.
// Frame is 10*CLK_DIV cycles; txOut lags state by one clock; inValid is ignored while busy.
`timescale 1ns/1ps
module mux_serial_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inValid,
  output logic       inReady,
  input  logic [7:0] inData,
  output logic [7:0] muxData,
  output logic [2:0] addr,
  input  logic       muxOut,
  output logic       txOut,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] divCnt;
  logic [2:0] bitCnt;
  logic       bitEnd;

  assign bitEnd = (divCnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      muxData <= 8'd0;
      addr    <= 3'd0;
      txOut   <= 1'b1;
      inReady <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bitCnt  <= 3'd0;
      divCnt  <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txOut <= 1'b1;
          if (inValid && inReady) begin
            muxData <= inData;
            divCnt  <= 8'd0;
            bitCnt  <= 3'd0;
            addr    <= 3'd0;
            inReady <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          txOut <= 1'b0;
          if (bitEnd) begin
            divCnt <= 8'd0;
            state  <= DATA;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        DATA: begin
          // muxOut is only trusted here, where addr/muxData are stable registers
          txOut <= muxOut;
          if (bitEnd) begin
            divCnt <= 8'd0;
            if (bitCnt == 3'd7) begin
              bitCnt <= 3'd0;
              addr   <= 3'd0;
              state  <= STOP;
            end else begin
              bitCnt <= bitCnt + 3'd1;
              addr   <= addr + 3'd1;
            end
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        STOP: begin
          txOut <= 1'b1;
          if (bitEnd) begin
            divCnt  <= 8'd0;
            done    <= 1'b1;
            inReady <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            divCnt <= divCnt + 8'd1;
          end
        end
        default: begin
          txOut   <= 1'b1;
          inReady <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serial_tx.sv
// Scoreboard bench for mux_serial_tx at CLK_DIV=4 and CLK_DIV=2 with a behavioural 8:1 mux.
`timescale 1ns/1ps
module tb_mux_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;        // 0 observes the CLK_DIV=4 instance, 1 the CLK_DIV=2 one
  logic       dataPhase = 1'b0;

  logic       inValid4 = 1'b0, inValid2 = 1'b0;
  logic [7:0] inData4 = 8'h00, inData2 = 8'h00;
  logic       inReady4, inReady2, muxOut4, muxOut2, txOut4, txOut2;
  logic       busy4, busy2, done4, done2;
  logic [7:0] muxData4, muxData2;
  logic [2:0] addr4, addr2;

  always #5 clk = ~clk;

  mux_serial_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inValid(inValid4), .inReady(inReady4),
    .inData(inData4), .muxData(muxData4), .addr(addr4), .muxOut(muxOut4),
    .txOut(txOut4), .busy(busy4), .done(done4)
  );

  mux_serial_tx #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .inValid(inValid2), .inReady(inReady2),
    .inData(inData2), .muxData(muxData2), .addr(addr2), .muxOut(muxOut2),
    .txOut(txOut2), .busy(busy2), .done(done2)
  );

  // Mux model; outside DATA it returns the wrong bit so a leak onto txOut is visible.
  assign muxOut4 = (dataPhase && !sel) ? muxData4[addr4] : ~muxData4[addr4];
  assign muxOut2 = (dataPhase && sel)  ? muxData2[addr2] : ~muxData2[addr2];

  logic       obsTx, obsDone, obsRdy, obsBusy;
  logic [2:0] obsAddr;
  logic [7:0] obsMd;
  assign obsTx   = sel ? txOut2   : txOut4;
  assign obsDone = sel ? done2    : done4;
  assign obsRdy  = sel ? inReady2 : inReady4;
  assign obsBusy = sel ? busy2    : busy4;
  assign obsAddr = sel ? addr2    : addr4;
  assign obsMd   = sel ? muxData2 : muxData4;

  typedef struct packed {
    logic       tx;
    logic [2:0] addr;
    logic       done;
    logic       rdy;
    logic       busy;
    logic [7:0] md;
    logic       isData;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Expected per-cycle view of a frame accepted at edge E; entry j is sampled after edge E+j.
  task automatic pushFrame(input logic [7:0] w, input int d);
    exp_t e;
    int   p;
    for (int j = 0; j <= 10 * d; j++) begin
      e.md     = w;
      e.done   = (j == 10 * d);
      e.rdy    = (j == 10 * d);
      e.busy   = (j < 10 * d);
      e.isData = (j >= d) && (j < 9 * d);
      e.addr   = e.isData ? 3'((j - d) / d) : 3'd0;
      p = j - 1;
      if (j == 0)         e.tx = 1'b1;
      else if (p < d)     e.tx = 1'b0;
      else if (p < 9 * d) e.tx = w[(p - d) / d];
      else                e.tx = 1'b1;
      q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per cycle while a frame is outstanding, else expects idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dataPhase = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        dataPhase = e.isData;
        checks++;
        if ({obsTx, obsAddr, obsDone, obsRdy, obsBusy, obsMd} !==
            {e.tx, e.addr, e.done, e.rdy, e.busy, e.md}) begin
          failures++;
          $display("FAIL frame_cycle t=%0t got tx=%b addr=%0d done=%b rdy=%b busy=%b md=%h exp tx=%b addr=%0d done=%b rdy=%b busy=%b md=%h",
                   $time, obsTx, obsAddr, obsDone, obsRdy, obsBusy, obsMd,
                   e.tx, e.addr, e.done, e.rdy, e.busy, e.md);
        end
      end else begin
        dataPhase = 1'b0;
        checks++;
        if ({obsTx, obsDone, obsRdy, obsBusy} !== 4'b1010) begin
          failures++;
          $display("FAIL idle_state t=%0t got tx=%b done=%b rdy=%b busy=%b exp tx=1 done=0 rdy=1 busy=0",
                   $time, obsTx, obsDone, obsRdy, obsBusy);
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic hold, output int accCyc);
    int n;
    @(negedge clk);
    if (sel) begin inValid2 = 1'b1; inData2 = w; end
    else     begin inValid4 = 1'b1; inData4 = w; end
    n = 0;
    while (!(obsRdy && rst_n) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=no_accept exp=accept word=%h", w);
      accCyc = -1;
      inValid2 = 1'b0;
      inValid4 = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      accCyc = cyc;
      pushFrame(w, sel ? 2 : 4);
      if (!hold) begin
        inValid2 = 1'b0;
        inValid4 = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dc, n;

    // Reset held while inValid toggles
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid4 = ~inValid4;
      inValid2 = ~inValid2;
      inData4  = 8'hE7;
      inData2  = 8'hE7;
    end
    #1;
    chk("rst_txOut", txOut4, 1);
    chk("rst_addr", addr4, 0);
    chk("rst_inReady", inReady4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_muxData", muxData4, 0);
    chk("rst_txOut_div2", txOut2, 1);
    inValid4 = 1'b0;
    inValid2 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5
    send(8'hA5, 1'b0, a1);
    drain();

    // Back-to-back 0x00 then 0xFF with inValid held
    send(8'h00, 1'b1, a1);
    send(8'hFF, 1'b0, a2);
    chk("b2b_spacing", a2 - a1, 41);
    drain();

    // inValid pulse while busy must be ignored
    send(8'h81, 1'b0, a1);
    repeat (12) @(negedge clk);
    inValid4 = 1'b1;
    inData4  = 8'h3C;
    #1 chk("busy_inReady_low", inReady4, 0);
    @(negedge clk);
    inValid4 = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    chk("no_extra_frame", busy4, 0);
    chk("busy_muxData_kept", muxData4, 8'h81);

    // Reset during DATA bit 3 (addr=3, line currently low)
    send(8'hC3, 1'b0, a1);
    repeat (17) @(posedge clk);
    #1 chk("pre_rst_addr", addr4, 3);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_txOut", txOut4, 1);
    chk("midrst_addr", addr4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_muxData", muxData4, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(8'h5A, 1'b0, a1);
    drain();

    // Minimum divider
    sel = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h01, 1'b0, a1);
    dc = -1;
    n = 0;
    while (dc < 0 && n < 100) begin
      @(negedge clk);
      if (done2) dc = cyc;
      n++;
    end
    chk("div2_frame_len", dc - a1, 20);
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
